// File: rtl/fast_pkg.sv
// fast_pkg: shared state encoding and corner record layout for the FAST stream controller.
package fast_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam int COORD_W = 10;
  localparam int X_OFF = 0;
  localparam int Y_OFF = COORD_W;
  localparam int SCORE_OFF = 2 * COORD_W;
endpackage

// File: rtl/fast_stream_ctrl_if.sv
// fast_stream_ctrl_if: pixel input stream, pipeline core strobes and corner record output stream.
interface fast_stream_ctrl_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int SCORE_WIDTH = 13
) ();
  import fast_pkg::*;
  logic                   s_valid;
  logic                   s_ready;
  logic                   s_sof;
  logic [PIXEL_WIDTH-1:0] s_data;
  logic                   core_ce;
  logic [PIXEL_WIDTH-1:0] core_data;
  logic                   core_iscorner;
  logic [SCORE_WIDTH-1:0] core_score;
  logic                   m_valid;
  logic                   m_ready;
  logic [COORD_W-1:0]     m_x;
  logic [COORD_W-1:0]     m_y;
  logic [SCORE_WIDTH-1:0] m_score;
  modport master (
    input  s_valid, s_sof, s_data, core_iscorner, core_score, m_ready,
    output s_ready, core_ce, core_data, m_valid, m_x, m_y, m_score
  );
  modport slave (
    output s_valid, s_sof, s_data, core_iscorner, core_score, m_ready,
    input  s_ready, core_ce, core_data, m_valid, m_x, m_y, m_score
  );
endinterface

// File: rtl/fast_corner_fifo.sv
// fast_corner_fifo: first-word-fall-through FIFO for corner records; push at full is taken only with a pop.
module fast_corner_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic we, re;
  assign re = pop && !empty;
  assign we = push && (!full || re);
  assign count = wp - rp;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (we) wp <= wp + 1'b1;
      if (re) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (we) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/fast_stream_ctrl.sv
// fast_stream_ctrl: sequences the FAST corner pipeline, tags results with centre coordinates and queues corners.
// Define FAST_CORNER_CNT_EN to add the per-frame corner_cnt output.
module fast_stream_ctrl
  import fast_pkg::*;
#(
  parameter int COL_NUM     = 640,
  parameter int ROW_NUM     = 480,
  parameter int PIXEL_WIDTH = 8,
  parameter int PIPE_LAT    = 8,
  parameter int BORDER      = 3,
  parameter int FIFO_DEPTH  = 16,
  parameter int SCORE_WIDTH = 13
) (
  input  logic clk,
  input  logic rst,
  fast_stream_ctrl_if.master bus,
  output logic frame_done,
  output logic sof_err
`ifdef FAST_CORNER_CNT_EN
  , output logic [19:0] corner_cnt
`endif
);
  localparam int N    = COL_NUM * ROW_NUM;
  localparam int LEAD = PIPE_LAT + 3 * COL_NUM + 3;
  localparam int W    = SCORE_OFF + SCORE_WIDTH;
  localparam int IW   = $clog2(N);
  localparam int CW   = $clog2(LEAD + 1);
  state_t state, nxt;
  logic act, live, start, trk, wrap, in_x, in_y, push, full, empty;
  logic [IW-1:0] in_cnt;
  logic [CW-1:0] ce_cnt;
  logic [COORD_W-1:0] rx, ry;
  logic [W-1:0] dout;
  logic [$clog2(FIFO_DEPTH):0] count;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    bus.s_ready = 1'b0;
    bus.core_ce = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        bus.s_ready = act;
        bus.core_ce = act && bus.s_valid && bus.s_sof;
        if (bus.core_ce) nxt = RUN;
      end
      RUN: begin
        bus.s_ready = act && !full;
        bus.core_ce = bus.s_valid && bus.s_ready;
        if (bus.core_ce && !bus.s_sof && in_cnt == IW'(N - 1)) nxt = FLUSH;
      end
      FLUSH: begin
        bus.core_ce = !full;
        if (bus.core_ce && in_cnt == IW'(PIPE_LAT - 1)) nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        nxt = IDLE;
      end
    endcase
  end
  // act keeps the stream closed while reset is held, since IDLE alone would advertise ready
  assign live = state == IDLE || state == RUN;
  assign bus.core_data = (act && live) ? bus.s_data : {PIXEL_WIDTH{1'b0}};
  assign start = bus.core_ce && bus.s_sof && live;
  assign trk = ce_cnt == CW'(LEAD);
  assign wrap = rx == COORD_W'(COL_NUM - 1);
  assign in_x = rx >= COORD_W'(BORDER) && rx <= COORD_W'(COL_NUM - 1 - BORDER);
  assign in_y = ry >= COORD_W'(BORDER) && ry <= COORD_W'(ROW_NUM - 1 - BORDER);
  assign push = bus.core_ce && !start && trk && bus.core_iscorner && in_x && in_y;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      act <= 1'b0;
      in_cnt <= '0;
      ce_cnt <= '0;
      rx <= '0;
      ry <= '0;
      sof_err <= 1'b0;
    end else begin
      act <= 1'b1;
      if (start) begin
        in_cnt <= IW'(1);
        ce_cnt <= CW'(1);
        rx <= '0;
        ry <= '0;
        if (state == RUN) sof_err <= 1'b1;
      end else if (bus.core_ce) begin
        in_cnt <= (nxt != state) ? '0 : in_cnt + 1'b1;
        if (trk) begin
          rx <= wrap ? '0 : rx + 1'b1;
          ry <= ry + COORD_W'(wrap);
        end else ce_cnt <= ce_cnt + 1'b1;
      end
    end
  fast_corner_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din({bus.core_score, ry, rx}),
    .pop(bus.m_valid && bus.m_ready),
    .dout(dout),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign bus.m_valid = |count;
  assign bus.m_x = empty ? '0 : dout[X_OFF +: COORD_W];
  assign bus.m_y = empty ? '0 : dout[Y_OFF +: COORD_W];
  assign bus.m_score = empty ? '0 : dout[SCORE_OFF +: SCORE_WIDTH];
`ifdef FAST_CORNER_CNT_EN
  logic [19:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      corner_cnt <= '0;
    end else begin
      if (start) cnt <= '0;
      else if (push && cnt != '1) cnt <= cnt + 1'b1;
      if (frame_done) corner_cnt <= cnt;
    end
`endif
endmodule

// File: tb/tb_fast_stream_ctrl.sv
// tb_fast_stream_ctrl: table vectors, directed frame sequences and randomized frames against a coordinate model.
module tb_fast_stream_ctrl;
  localparam int COL = 16, ROW = 12, LAT = 4, BRD = 3, DEP = 4, SW = 13;
  localparam int N = COL * ROW, LEAD = LAT + 3 * COL + 3;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  fast_stream_ctrl_if #(.PIXEL_WIDTH(8), .SCORE_WIDTH(SW)) bus ();
  logic frame_done, sof_err;
`ifdef FAST_CORNER_CNT_EN
  logic [19:0] corner_cnt;
`endif
  fast_stream_ctrl #(.COL_NUM(COL), .ROW_NUM(ROW), .PIXEL_WIDTH(8), .PIPE_LAT(LAT),
                     .BORDER(BRD), .FIFO_DEPTH(DEP), .SCORE_WIDTH(SW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .frame_done(frame_done),
    .sof_err(sof_err)
`ifdef FAST_CORNER_CNT_EN
    , .corner_cnt(corner_cnt)
`endif
  );
  typedef struct {int x; int y; int s;} rec_t;
  typedef struct {logic v; logic s; logic [7:0] d; logic rdy; logic ce; logic err;} vec_t;
  rec_t exp_q[$];
  rec_t last_rec;
  int n_cmp = 0, n_bad = 0;
  int ce_k, pix, fl_ce, n_rec, n_done, done_pix, done_fl, sent;
  int cmode = 0, mr_mode = 1;
  logic infr;
  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  // model: the k-th ce of a frame carries centre k-LEAD in raster order
  task automatic monitor();
    logic acc;
    rec_t r;
    int c;
    if (!rst) begin
      ce_k = 0; pix = 0; fl_ce = 0; n_rec = 0; n_done = 0; infr = 1'b0;
      done_pix = -1; done_fl = -1;
      exp_q.delete();
      return;
    end
    acc = bus.s_valid && bus.s_ready;
    if (!(infr && pix == N)) check("core_ce", bus.core_ce, acc && (infr || bus.s_sof));
    if (bus.core_ce && acc) check("core_data", bus.core_data, bus.s_data);
    if (acc && bus.s_sof) begin
      ce_k = 0; pix = 0; fl_ce = 0; infr = 1'b1;
    end
    if (acc && infr) pix++;
    if (bus.core_ce) begin
      if (!acc) fl_ce++;
      if (ce_k >= LEAD) begin
        c = ce_k - LEAD;
        r.x = c % COL; r.y = c / COL; r.s = bus.core_score;
        if (bus.core_iscorner && r.x >= BRD && r.x <= COL - 1 - BRD && r.y >= BRD && r.y <= ROW - 1 - BRD)
          exp_q.push_back(r);
      end
      ce_k++;
    end
    if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) check("unexpected_record", 1, 0);
      else begin
        r = exp_q.pop_front();
        check("m_x", bus.m_x, r.x);
        check("m_y", bus.m_y, r.y);
        check("m_score", bus.m_score, r.s);
      end
      last_rec = '{bus.m_x, bus.m_y, bus.m_score};
      n_rec++;
    end
    if (frame_done) begin
      n_done++; done_pix = pix; done_fl = fl_ce; infr = 1'b0;
    end
  endtask
  task automatic tick(input logic v, input logic s, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus.s_valid = v;
    bus.s_sof = s;
    bus.s_data = d;
    bus.core_iscorner = cmode == 0 ? 1'b1 : cmode == 1 ? (ce_k == LEAD + COL * 5 + 7) : ($urandom % 4 == 0);
    bus.core_score = SW'($urandom);
    bus.m_ready = mr_mode == 2 ? 1'($urandom % 2) : 1'(mr_mode);
    @(negedge clk);
    monitor();
  endtask
  task automatic do_reset();
    rst = 1'b0;
    sent = 0;
    repeat (3) tick(1'b0, 1'b0, 8'h0);
    rst = 1'b1;
    repeat (2) tick(1'b0, 1'b0, 8'h0);
  endtask
  task automatic drive_pixels(input int npix, input int sof2, input int vmode, input int tmax);
    int t = 0;
    logic v;
    while (sent < npix && t < tmax) begin
      v = vmode != 0 ? ($urandom % 3 != 0) : 1'b1;
      tick(v, sent == 0 || sent == sof2, 8'($urandom));
      if (v && bus.s_ready) sent++;
      t++;
    end
  endtask
  task automatic wait_done();
    int t = 0;
    while (n_done == 0 && t < 2000) begin
      tick(1'b0, 1'b0, 8'h0);
      t++;
    end
    check("frame_done_seen", n_done, 1);
    mr_mode = 1;
    t = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && t < 200) begin
      tick(1'b0, 1'b0, 8'h0);
      t++;
    end
    repeat (3) tick(1'b0, 1'b0, 8'h0);
    check("drained", exp_q.size(), 0);
    check("frame_done_once", n_done, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t tbl[10];
    tbl[0] = '{1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 8'h66, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 8'h88, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 8'h99, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b1};
    bus.s_valid = 1'b1; bus.s_sof = 1'b1; bus.s_data = 8'h5A;
    bus.core_iscorner = 1'b1; bus.core_score = '1; bus.m_ready = 1'b1;
    @(negedge clk);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_core_ce", bus.core_ce, 0);
    check("rst_core_data", bus.core_data, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_x", bus.m_x, 0);
    check("rst_m_y", bus.m_y, 0);
    check("rst_m_score", bus.m_score, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_sof_err", sof_err, 0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].v, tbl[i].s, tbl[i].d);
      check($sformatf("vec%0d_s_ready", i), bus.s_ready, tbl[i].rdy);
      check($sformatf("vec%0d_core_ce", i), bus.core_ce, tbl[i].ce);
      check($sformatf("vec%0d_sof_err", i), sof_err, tbl[i].err);
      if (tbl[i].ce) check($sformatf("vec%0d_core_data", i), bus.core_data, tbl[i].d);
    end
    do_reset();
    check("sof_err_cleared", sof_err, 0);
    // full frame, every result a corner
    cmode = 0; mr_mode = 1;
    drive_pixels(N, -1, 0, 4000);
    check("A_pixels", sent, N);
    wait_done();
    check("A_records", n_rec, 60);
    check("A_flush_ce", done_fl, LAT);
    check("A_done_pix", done_pix, N);
`ifdef FAST_CORNER_CNT_EN
    check("A_corner_cnt", corner_cnt, 60);
`endif
    // single corner at centre (7,5)
    do_reset();
    cmode = 1;
    drive_pixels(N, -1, 0, 4000);
    wait_done();
    check("B_records", n_rec, 1);
    check("B_x", last_rec.x, 7);
    check("B_y", last_rec.y, 5);
    // downstream stalled: FIFO fills and the source is held off
    do_reset();
    cmode = 0; mr_mode = 0;
    drive_pixels(N, -1, 0, 150);
    check("C_s_ready_held", bus.s_ready, 0);
    check("C_core_ce_held", bus.core_ce, 0);
    check("C_m_valid", bus.m_valid, 1);
    check("C_fifo_entries", exp_q.size(), DEP);
    check("C_no_pops", n_rec, 0);
    mr_mode = 1;
    drive_pixels(N, -1, 0, 4000);
    check("C_pixels", sent, N);
    wait_done();
    check("C_records", n_rec, 60);
    // second SOF at pixel 50 restarts the frame
    do_reset();
    drive_pixels(50 + N, 50, 0, 4000);
    check("D_sof_err", sof_err, 1);
    wait_done();
    check("D_done_pix", done_pix, N);
    check("D_records", n_rec, 60);
    // asynchronous reset during FLUSH
    do_reset();
    drive_pixels(N, -1, 0, 4000);
    @(posedge clk);
    #2;
    check("E_pre_m_valid", bus.m_valid, 1);
    rst = 1'b0;
    #1;
    check("E_m_valid", bus.m_valid, 0);
    check("E_core_ce", bus.core_ce, 0);
    check("E_s_ready", bus.s_ready, 0);
    check("E_frame_done", frame_done, 0);
    check("E_m_x", bus.m_x, 0);
    repeat (2) tick(1'b0, 1'b0, 8'h0);
    rst = 1'b1;
    repeat (30) tick(1'b0, 1'b0, 8'h0);
    check("E_no_frame_done", n_done, 0);
    check("E_idle_ready", bus.s_ready, 1);
    // randomized frames: valid gaps, random backpressure and corner flags
    do_reset();
    for (int f = 0; f < 3; f++) begin
      cmode = 2; mr_mode = 2; n_done = 0; sent = 0;
      drive_pixels(N, -1, 1, 4000);
      check("F_pixels", sent, N);
      wait_done();
      check("F_flush_ce", done_fl, LAT);
      check("F_done_pix", done_pix, N);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
